// File: rtl/seg7_scan_decoder_if.sv
// Bus between a seven-segment scan driver and the scan decoder monitor.
// The master drives segment/anode lines; the slave publishes decoded frames.
interface seg7_scan_decoder_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic [4:0] min_l;
  logic [4:0] min_r;
  logic [4:0] sec_l;
  logic [4:0] sec_r;
  logic       frame_valid;
  logic       bad_seg;
  logic       scan_lost;

  modport master (
    output seg, an,
    input  min_l, min_r, sec_l, sec_r, frame_valid, bad_seg, scan_lost
  );

  modport slave (
    input  seg, an,
    output min_l, min_r, sec_l, sec_r, frame_valid, bad_seg, scan_lost
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment display, decodes each settled
// digit slot and publishes coherent four-digit frames; flags bad patterns and stalls.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 2097152
) (
  input  logic                 clk,
  input  logic                 btn_reset,
  seg7_scan_decoder_if.slave   bus
);

  localparam int unsigned SW       = $clog2(SETTLE + 1);
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam int unsigned DW       = 5;
  localparam logic [4:0]  CODE_BLANK = 5'd16;
  localparam logic [4:0]  CODE_BAD   = 5'd31;

  logic [6:0]          seg_m_q, seg_s_q;
  logic [3:0]          an_m_q,  an_s_q, an_p_q;
  logic [SW-1:0]       st_cnt_q, st_cnt_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic [3:0]          mask_q, mask_d;
  logic [3:0][DW-1:0]  pend_q, pend_d;
  logic [3:0][DW-1:0]  dig_q, dig_d;
  logic                fv_q, fv_d;
  logic                bad_q, bad_d;
  logic                lost_q, lost_d;

  logic                an_valid;
  logic                capture;
  logic [DW-1:0]       code;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'd0;
      7'b1111001: decode = 5'd1;
      7'b0100100: decode = 5'd2;
      7'b0110000: decode = 5'd3;
      7'b0011001: decode = 5'd4;
      7'b0010010: decode = 5'd5;
      7'b0000010: decode = 5'd6;
      7'b1111000: decode = 5'd7;
      7'b0000000: decode = 5'd8;
      7'b0010000: decode = 5'd9;
      7'b1111111: decode = CODE_BLANK;
      default:    decode = CODE_BAD;
    endcase
  endfunction

  // Next-state: settle counter, slot capture, frame assembly and stall watchdog.
  always_comb begin
    st_cnt_d = st_cnt_q;
    to_cnt_d = to_cnt_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    dig_d    = dig_q;
    fv_d     = 1'b0;
    bad_d    = bad_q;
    lost_d   = lost_q;

    an_valid = $onehot(~an_s_q);
    code     = decode(seg_s_q);
    capture  = an_valid && (an_s_q == an_p_q) && (st_cnt_q == SW'(SETTLE - 1));

    if (!an_valid || (an_s_q != an_p_q)) begin
      st_cnt_d = '0;
    end else if (st_cnt_q != SW'(SETTLE)) begin
      st_cnt_d = st_cnt_q + SW'(1);
    end

    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (!an_s_q[i]) begin
          pend_d[i] = code;
          mask_d[i] = 1'b1;
        end
      end
      if (code == CODE_BAD) begin
        bad_d = 1'b1;
      end
    end

    // A capture always resets the watchdog, so it wins over saturation.
    if (capture) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TW'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_d == TW'(TIMEOUT)) begin
        mask_d = '0;
      end
    end
    lost_d = (to_cnt_d == TW'(TIMEOUT));

    if (mask_d == 4'hF) begin
      dig_d  = pend_d;
      fv_d   = 1'b1;
      mask_d = '0;
    end
  end

  // Synchronizers idle high so reset looks like a blanked, unselected display.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      seg_m_q  <= '1;
      seg_s_q  <= '1;
      an_m_q   <= '1;
      an_s_q   <= '1;
      an_p_q   <= '1;
      st_cnt_q <= '0;
      to_cnt_q <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      dig_q    <= {4{CODE_BLANK}};
      fv_q     <= 1'b0;
      bad_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      seg_m_q  <= bus.seg;
      seg_s_q  <= seg_m_q;
      an_m_q   <= bus.an;
      an_s_q   <= an_m_q;
      an_p_q   <= an_s_q;
      st_cnt_q <= st_cnt_d;
      to_cnt_q <= to_cnt_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      dig_q    <= dig_d;
      fv_q     <= fv_d;
      bad_q    <= bad_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.min_l       = dig_q[3];
  assign bus.min_r       = dig_q[2];
  assign bus.sec_l       = dig_q[1];
  assign bus.sec_r       = dig_q[0];
  assign bus.frame_valid = fv_q;
  assign bus.bad_seg     = bad_q;
  assign bus.scan_lost   = lost_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digit frames, glitches, bad
// patterns, stall timeout and mid-frame reset against hand-computed results.
module tb_seg7_scan_decoder;

  localparam int unsigned SETTLE  = 16;
  localparam int unsigned TIMEOUT = 1000;
  localparam int          DWELL   = 256;

  logic clk = 1'b0;
  logic btn_reset;
  int   cyc = 0;
  int   fv_cnt = 0;
  int   fv_cyc = -1;
  int   drv_cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    @(negedge clk);
    bus.an  = a;
    bus.seg = s;
    drv_cyc = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slot(input logic [3:0] a, input logic [6:0] s, input int n);
    drive(a, s);
    hold(n - 1);
  endtask

  task automatic check_frame(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_min_l"}, 32'(bus.min_l), 32'(a));
    check({tag, "_min_r"}, 32'(bus.min_r), 32'(b));
    check({tag, "_sec_l"}, 32'(bus.sec_l), 32'(c));
    check({tag, "_sec_r"}, 32'(bus.sec_r), 32'(d));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0;
    int cap;
    int sec_drv;

    bus.an    = 4'hF;
    bus.seg   = 7'h7F;
    btn_reset = 1'b0;
    hold(3);
    check_frame("reset", 16, 16, 16, 16);
    check("reset_fv",   32'(bus.frame_valid), 32'd0);
    check("reset_bad",  32'(bus.bad_seg),     32'd0);
    check("reset_lost", 32'(bus.scan_lost),   32'd0);
    btn_reset = 1'b1;

    // Basic frame 5,6,7,8 and capture latency of the final slot
    f0 = fv_cnt;
    slot(4'b0111, seg_of(5), DWELL);
    slot(4'b1011, seg_of(6), DWELL);
    slot(4'b1101, seg_of(7), DWELL);
    drive(4'b1110, seg_of(8));
    sec_drv = drv_cyc;
    hold(DWELL - 1);
    check("basic_fv_count", 32'(fv_cnt - f0), 32'd1);
    check("basic_latency",  32'(fv_cyc - sec_drv), 32'(3 + SETTLE));
    check_frame("basic", 5, 6, 7, 8);
    check("basic_bad", 32'(bus.bad_seg), 32'd0);

    // Short min_r glitch must not fill that slot
    f0 = fv_cnt;
    slot(4'b0111, seg_of(1), DWELL);
    slot(4'b1011, seg_of(9), 10);
    slot(4'b0111, seg_of(1), DWELL);
    slot(4'b1101, seg_of(3), DWELL);
    slot(4'b1110, seg_of(4), DWELL);
    check("glitch_no_frame", 32'(fv_cnt - f0), 32'd0);
    slot(4'b1011, seg_of(2), DWELL);
    check("glitch_fv_count", 32'(fv_cnt - f0), 32'd1);
    check_frame("glitch", 1, 2, 3, 4);

    // Late segment change ignored; blank and bad patterns decoded
    slot(4'b0111, seg_of(3), 69);
    slot(4'b0111, seg_of(9), DWELL - 69);
    slot(4'b1011, seg_of(0), DWELL);
    slot(4'b1101, 7'b1111111, DWELL);
    slot(4'b1110, 7'b0101010, DWELL);
    check_frame("badpat", 3, 0, 16, 31);
    check("badpat_bad", 32'(bus.bad_seg), 32'd1);

    slot(4'b0111, seg_of(9), DWELL);
    slot(4'b1011, seg_of(8), DWELL);
    slot(4'b1101, seg_of(7), DWELL);
    slot(4'b1110, seg_of(6), DWELL);
    check_frame("clean", 9, 8, 7, 6);
    check("bad_sticky", 32'(bus.bad_seg), 32'd1);

    // Stall after two slots: timeout, hold outputs, mask discarded
    slot(4'b0111, seg_of(1), DWELL);
    drive(4'b1011, seg_of(1));
    cap = drv_cyc + 3 + int'(SETTLE);
    hold(DWELL - 1);
    f0 = fv_cnt;
    drive(4'b1111, 7'h7F);
    for (int g = 0; g < 5000 && cyc < cap + int'(TIMEOUT) - 1; g++) @(negedge clk);
    check("lost_before", 32'(bus.scan_lost), 32'd0);
    hold(1);
    check("lost_rise",   32'(bus.scan_lost), 32'd1);
    check_frame("lost_hold", 9, 8, 7, 6);
    hold(20);
    drive(4'b1101, seg_of(5));
    hold(2 + SETTLE);
    check("lost_pre_capture", 32'(bus.scan_lost), 32'd1);
    hold(1);
    check("lost_cleared",     32'(bus.scan_lost), 32'd0);
    hold(DWELL - 4 - SETTLE);
    slot(4'b1110, seg_of(5), DWELL);
    check("lost_mask_cleared", 32'(fv_cnt - f0), 32'd0);
    slot(4'b0111, seg_of(2), DWELL);
    slot(4'b1011, seg_of(3), DWELL);
    check("resume_fv_count", 32'(fv_cnt - f0), 32'd1);
    check_frame("resume", 2, 3, 5, 5);

    // Asynchronous reset in the middle of a frame
    slot(4'b0111, seg_of(4), DWELL);
    slot(4'b1011, seg_of(4), DWELL);
    drive(4'b1101, seg_of(5));
    hold(30);
    btn_reset = 1'b0;
    #1;
    check_frame("mid_reset", 16, 16, 16, 16);
    check("mid_reset_fv",   32'(bus.frame_valid), 32'd0);
    check("mid_reset_bad",  32'(bus.bad_seg),     32'd0);
    check("mid_reset_lost", 32'(bus.scan_lost),   32'd0);
    drive(4'b1111, 7'h7F);
    hold(3);
    btn_reset = 1'b1;
    f0 = fv_cnt;
    slot(4'b1101, seg_of(5), DWELL);
    slot(4'b1110, seg_of(5), DWELL);
    check("post_reset_no_frame", 32'(fv_cnt - f0), 32'd0);
    check("post_reset_hold", 32'(bus.min_l), 32'd16);
    slot(4'b0111, seg_of(7), DWELL);
    slot(4'b1011, seg_of(1), DWELL);
    check("post_reset_fv_count", 32'(fv_cnt - f0), 32'd1);
    check_frame("post_reset", 7, 1, 5, 5);
    check("post_reset_bad", 32'(bus.bad_seg), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
